// File: rtl/aes_pkg.sv
// Shared types and byte/matrix mapping for the
// iterative AES-128 round sequencer.
package aes_pkg;

  localparam int NB      = 4;
  localparam int BLOCK_W = 128;

  typedef logic [7:0] byte_t;

  typedef byte_t [NB-1:0][NB-1:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } seq_state_e;

  // byte k of the block is matrix[r][c], k = 4c+r
  function automatic state_t to_matrix(
    input logic [BLOCK_W-1:0] b
  );
    state_t m;
    for (int r = 0; r < NB; r++) begin
      for (int c = 0; c < NB; c++) begin
        m[r][c] = b[8*(4*c+r) +: 8];
      end
    end
    return m;
  endfunction

  function automatic logic [BLOCK_W-1:0] to_block(
    input state_t m
  );
    logic [BLOCK_W-1:0] b;
    for (int r = 0; r < NB; r++) begin
      for (int c = 0; c < NB; c++) begin
        b[8*(4*c+r) +: 8] = m[r][c];
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/aes_state_reg.sv
// 4x4 byte state matrix register with synchronous
// clear and load, exposed as a flat 128-bit vector.
module aes_state_reg
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               ld,
  input  state_t             d,
  output logic [BLOCK_W-1:0] flat
);

  state_t mat_q, mat_d;

  // clear has priority over load
  always_comb begin
    mat_d = mat_q;
    if (clr) begin
      mat_d = '0;
    end else if (ld) begin
      mat_d = d;
    end
  end

  // matrix storage
  always_ff @(posedge clk) begin
    mat_q <= mat_d;
  end

  assign flat = to_block(mat_q);

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller: initial AddRoundKey,
// NR datapath rounds, then ciphertext handshake.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR  = 10,
  parameter int RIW = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_block,
  output logic [RIW-1:0]     rk_idx,
  input  logic [BLOCK_W-1:0] rk_data,
  output logic [BLOCK_W-1:0] rd_state,
  output logic               rd_final,
  input  logic [BLOCK_W-1:0] rd_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_block,
  output logic               busy
);

  seq_state_e         st_q, st_d;
  logic [RIW-1:0]     round_q, round_d;
  logic               ld;
  state_t             ld_val;
  logic               last;
  logic [BLOCK_W-1:0] flat;

  assign last = (round_q == RIW'(NR));

  // next state, round counter and handshake outputs
  always_comb begin
    st_d      = st_q;
    round_d   = round_q;
    ld        = 1'b0;
    ld_val    = to_matrix(rd_result);
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rd_final  = 1'b0;
    rk_idx    = '0;
    unique case (st_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld      = 1'b1;
          ld_val  = to_matrix(in_block ^ rk_data);
          round_d = RIW'(1);
          st_d    = ROUND;
        end
      end
      ROUND: begin
        rk_idx   = round_q;
        rd_final = last;
        ld       = 1'b1;
        if (last) begin
          st_d = DONE;
        end else begin
          round_d = round_q + RIW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          st_d    = IDLE;
          round_d = '0;
        end
      end
      default: begin
        st_d    = IDLE;
        round_d = '0;
      end
    endcase
  end

  // FSM and round counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= IDLE;
      round_q <= '0;
    end else begin
      st_q    <= st_d;
      round_q <= round_d;
    end
  end

  aes_state_reg u_state (
    .clk  (clk),
    .clr  (reset),
    .ld   (ld),
    .d    (ld_val),
    .flat (flat)
  );

  assign rd_state  = flat;
  assign out_block = flat;
  assign busy      = (st_q != IDLE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer with a
// behavioural AES-128 datapath, key schedule and model.
module tb_aes_round_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic [127:0] rd_state;
  logic         rd_final;
  logic [127:0] rd_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;
  bit mode  = 1'b0;
  logic [10:0][127:0] rks;

  always #5 clk = ~clk;

  aes_round_sequencer #(.NR(10), .RIW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .rd_state  (rd_state),
    .rd_final  (rd_final),
    .rd_result (rd_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a, input logic [7:0] b
  );
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e = 8'd254;
    logic [7:0] s;
    logic [7:0] v;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    s = r ^ 8'h63;
    v = r;
    for (int i = 0; i < 4; i++) begin
      v = rol1(v);
      s = s ^ v;
    end
    return s;
  endfunction

  function automatic logic [127:0] aes_rnd(
    input logic [127:0] s, input logic [127:0] rk,
    input logic fin
  );
    logic [7:0] b[16];
    logic [7:0] t[16];
    logic [7:0] m[16];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) b[k] = sbox(s[8*k +: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = b[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = t[4*c]; a1 = t[4*c+1];
      a2 = t[4*c+2]; a3 = t[4*c+3];
      if (fin) begin
        m[4*c] = a0; m[4*c+1] = a1;
        m[4*c+2] = a2; m[4*c+3] = a3;
      end else begin
        m[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        m[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        m[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        m[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int k = 0; k < 16; k++) o[8*k +: 8] = m[k];
    return o ^ rk;
  endfunction

  function automatic logic [10:0][127:0] expand(
    input logic [127:0] key
  );
    logic [43:0][31:0] w;
    logic [10:0][127:0] o;
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[7:0], t[31:8]};
        for (int j = 0; j < 4; j++) t[8*j +: 8] = sbox(t[8*j +: 8]);
        t[7:0] = t[7:0] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      o[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    return o;
  endfunction

  function automatic logic [127:0] aes_ref(
    input logic [127:0] blk, input logic [127:0] key
  );
    logic [10:0][127:0] k = expand(key);
    logic [127:0] s = blk ^ k[0];
    for (int r = 1; r <= 10; r++) s = aes_rnd(s, k[r], r == 10);
    return s;
  endfunction

  // FIPS byte-string order to column-major flat order
  function automatic logic [127:0] brev(input logic [127:0] v);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = v[8*(15-k) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // external key schedule and round datapath
  always_comb begin
    if (mode) begin
      rk_data   = {16{4'h0, rk_idx}};
      rd_result = rd_state ^ rk_data;
    end else begin
      rk_data   = (rk_idx <= 4'd10) ? rks[int'(rk_idx)] : '0;
      rd_result = aes_rnd(rd_state, rk_data, rd_final);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string tag, input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(
    input logic [127:0] blk, input int bp, input bit inj,
    output logic [127:0] res
  );
    int n = 0;
    int lat;
    while (!in_ready && n < 20) begin step(); n++; end
    chk("in_ready_wait", in_ready, 1);
    chk("idle_rk_idx", rk_idx, 0);
    in_block = blk;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_block = rnd128();
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("rk_idx", rk_idx, lat);
      chk("rd_final", rd_final, lat == 10);
      chk("round_busy", busy, 1);
      if (inj && lat == 3) begin
        in_valid = 1'b1;
        in_block = ~blk;
      end else begin
        in_valid = 1'b0;
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, 11);
    chk("done_rd_final", rd_final, 0);
    res = out_block;
    for (int i = 0; i < bp; i++) begin
      out_ready = 1'b0;
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_hold", out_block, res);
      chk("bp_in_ready", in_ready, 0);
    end
    chk("done_busy", busy, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    logic [127:0] fkey, pt, ct, res, a, b, x, key, exp;
    logic [127:0] outs[2];
    int acc[2];
    int n, cyc, nacc, nout;
    bit seen;

    fkey = brev(128'h000102030405060708090a0b0c0d0e0f);
    pt   = brev(128'h00112233445566778899aabbccddeeff);
    ct   = brev(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    rks  = expand(fkey);

    reset     = 1'b1;
    in_valid  = 1'b1;
    in_block  = rnd128();
    out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_final", rd_final, 0);
    chk("rst_rk_idx", rk_idx, 0);
    chk("rst_out_block", out_block, 0);
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("rst_no_accept", busy, 0);

    send(pt, 0, 1'b0, res);
    chk("fips_vector", res, ct);

    mode = 1'b1;
    send('0, 0, 1'b0, res);
    exp = '0;
    for (int i = 0; i <= 10; i++) exp ^= {16{4'h0, 4'(i)}};
    chk("stub_result", res, exp);
    mode = 1'b0;

    send(pt, 5, 1'b0, res);
    chk("bp_result", res, ct);

    key = rnd128();
    rks = expand(key);
    a = rnd128();
    send(a, 0, 1'b1, res);
    chk("inject_result", res, aes_ref(a, key));
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid || busy) seen = 1'b1;
      step();
    end
    chk("inject_no_extra", seen, 0);

    x = rnd128();
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    in_block = x;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (rk_idx != 4'd4 && n < 20) begin step(); n++; end
    chk("mid_reach_r4", rk_idx, 4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_rk_idx", rk_idx, 0);
    chk("mid_out_block", out_block, 0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    chk("mid_no_output", seen, 0);
    a = rnd128();
    send(a, 1, 1'b0, res);
    chk("mid_fresh", res, aes_ref(a, key));

    a = rnd128();
    b = rnd128();
    out_ready = 1'b1;
    in_block  = a;
    in_valid  = 1'b1;
    cyc = 0; nacc = 0; nout = 0;
    acc[0] = 0; acc[1] = 0;
    outs[0] = '0; outs[1] = '0;
    while (nout < 2 && cyc < 100) begin
      if (in_valid && in_ready && nacc < 2) begin
        acc[nacc] = cyc;
        nacc++;
      end
      if (out_valid) begin
        outs[nout] = out_block;
        nout++;
      end
      step();
      cyc++;
      if (nacc == 1) in_block = b;
      if (nacc == 2) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_accepts", nacc, 2);
    chk("b2b_spacing", acc[1] - acc[0], 12);
    chk("b2b_out0", outs[0], aes_ref(a, key));
    chk("b2b_out1", outs[1], aes_ref(b, key));
    step();

    for (int t = 0; t < 6; t++) begin
      key = rnd128();
      rks = expand(key);
      a = rnd128();
      send(a, int'($urandom_range(0, 3)), 1'b0, res);
      chk("rand_result", res, aes_ref(a, key));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
